mam_mem_responder: RTL and testbench
====================================

MAM_MEM_RESPONDER -- requirements
Module: mam_mem_responder

Purpose: memory-side responder for the MAM request interface. It accepts single or burst read/write requests and serves them from a synchronous single-port SRAM with 1-cycle read latency.

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: data bits per beat; a power of two, at least 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 64: request byte-address width.
REQ-003 SHALL have parameter MEM_AW, default 10: SRAM word-address width.
REQ-004 SHALL have parameter BASE_ADDR, default 0: byte address of SRAM word 0.
REQ-005 SHALL have ports, in this order:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted.
- req_rw  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  start byte address.
- req_burst  in  1  1 = burst of req_beats beats; 0 = single beat.
- req_beats  in  14  burst length.
- write_valid, write_ready  in/out  1  write-data handshake.
- write_data  in  DATA_WIDTH  write beat data.
- write_strb  in  DATA_WIDTH/8  byte enables.
- read_valid, read_ready  out/in  1  read-data handshake.
- read_data  out  DATA_WIDTH  read beat data.
- mem_en  out  1  SRAM access strobe.
- mem_we  out  1  SRAM write enable.
- mem_addr  out  MEM_AW  SRAM word address.
- mem_wdata  out  DATA_WIDTH  SRAM write data.
- mem_wstrb  out  DATA_WIDTH/8  SRAM byte enables.
- mem_rdata  in  DATA_WIDTH  SRAM read data, valid one cycle after mem_en with mem_we=0.
- busy  out  1  request in progress.
- err  out  1  one-cycle pulse per out-of-range beat.

Function
REQ-006 SHALL implement FSM states IDLE, WR, RD_ADDR, RD_WAIT, RD_DATA.
REQ-007 SHALL drive req_ready=1 only in IDLE; a request is accepted on a cycle where req_valid && req_ready.
REQ-008 SHALL, on acceptance, latch the address into cur_addr and set remaining = req_burst ? max(req_beats,1) : 1, ignoring req_beats when req_burst=0.
REQ-009 SHALL go from IDLE to WR on accept with req_rw=1, and to RD_ADDR on accept with req_rw=0.
REQ-010 SHALL compute in-range as cur_addr >= BASE_ADDR && (cur_addr-BASE_ADDR) < 2^MEM_AW*(DATA_WIDTH/8).
REQ-011 SHALL compute mem_addr = (cur_addr-BASE_ADDR) >> log2(DATA_WIDTH/8); address bits below the word size are ignored.
REQ-012 WR: SHALL hold write_ready=1.
REQ-013 WR: on a cycle with write_valid, SHALL drive, combinationally in that same cycle, mem_en=in-range, mem_we=1, mem_wdata=write_data, mem_wstrb=write_strb.
REQ-014 WR: SHALL drop an out-of-range beat (mem_en=0) and pulse err.
REQ-015 After each data beat, SHALL advance cur_addr by DATA_WIDTH/8, computed modulo 2^ADDR_WIDTH, and decrement remaining.
REQ-016 SHALL return to IDLE after the beat where remaining=1; for writes this is on write_valid, for reads on read_ready.
REQ-017 RD_ADDR: SHALL drive mem_en=in-range and mem_we=0 for exactly one cycle, then move to RD_WAIT.
REQ-018 RD_WAIT: SHALL capture mem_rdata into a hold register, or zero if the beat is out of range, pulse err if out of range, then move to RD_DATA.
REQ-019 RD_DATA: SHALL assert read_valid with read_data equal to the hold register, stable until read_ready.
REQ-020 RD_DATA: on read_ready, SHALL go to RD_ADDR if beats remain, otherwise to IDLE.
REQ-021 Read latency SHALL be: accept at cycle 0, mem_en at cycle 1, read_valid first at cycle 3; each further beat adds 3 cycles plus any backpressure.
REQ-022 SHALL keep write_ready=0 and read_valid=0 outside WR and RD_DATA respectively.
REQ-023 SHALL drive busy=1 in every state except IDLE.
REQ-024 SHALL not assert mem_en in IDLE, and SHALL not assert mem_en with mem_we=1 outside WR.
REQ-025 SHALL ignore req_valid while busy; a new request is sampled only after returning to IDLE, giving at least one idle cycle between requests.

Reset
REQ-026 SHALL, on rst assertion and asynchronously to clk, enter IDLE, clear cur_addr, remaining and the hold register, and drive req_ready=0, write_ready=0, read_valid=0, mem_en=0, busy=0, err=0.
REQ-027 SHALL raise req_ready=1 in the first cycle after rst deasserts.
REQ-028 SHALL abandon any in-progress request on reset mid-burst; no further mem_en is issued and the remaining beats are not served.

Verification
REQ-029 Single write then read (DW=64): write addr 0x10, data 0xA5A5_0000_1111_2222, strb 0xFF -> mem_en/we at word 2; the subsequent single read returns the same data, with read_valid at cycle 3 after accept.
REQ-030 Burst write, 4 beats from 0x0 with write_valid gapped every other cycle -> exactly 4 SRAM writes, to words 0,1,2,3, each in its write_valid cycle; req_ready returns after beat 4.
REQ-031 Burst read, 3 beats, read_ready held low 5 cycles on beat 2 -> read_data stable throughout the stall; beats arrive in word order; no extra mem_en.
REQ-032 Range edges with MEM_AW=10: read at 0x1FF8 -> word 1023 served, err=0; read at 0x2000 -> read_data=0, err pulses once, mem_en never asserted.
REQ-033 Edge lengths: req_burst=1, req_beats=0 -> exactly 1 beat; req_burst=0, req_beats=7 -> exactly 1 beat.
REQ-034 Reset mid-operation: assert rst during beat 2 of a 4-beat write -> all outputs clear immediately; after release req_ready=1 and no residual SRAM writes occur.

Source files
------------

// File: rtl/mam_mem_responder.sv
// Memory-side responder for the MAM request interface: serves single and burst
// read/write requests from a synchronous single-port SRAM with 1-cycle read latency.
module mam_mem_responder #(
    parameter int unsigned           DATA_WIDTH = 64,
    parameter int unsigned           ADDR_WIDTH = 64,
    parameter int unsigned           MEM_AW     = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_rw,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic                    req_burst,
    input  logic [13:0]             req_beats,
    input  logic                    write_valid,
    output logic                    write_ready,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic [DATA_WIDTH/8-1:0] write_strb,
    output logic                    read_valid,
    input  logic                    read_ready,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [MEM_AW-1:0]       mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    busy,
    output logic                    err
);

    localparam int unsigned STRB_W   = DATA_WIDTH / 8;
    localparam int unsigned BYTE_SH  = $clog2(STRB_W);
    localparam int unsigned RANGE_SH = MEM_AW + BYTE_SH;
    localparam int unsigned BEAT_W   = 14;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR      = 3'd1;
    localparam logic [2:0] S_RD_ADDR = 3'd2;
    localparam logic [2:0] S_RD_WAIT = 3'd3;
    localparam logic [2:0] S_RD_DATA = 3'd4;

    logic [2:0]            state, state_nxt;
    logic [ADDR_WIDTH-1:0] cur_addr, cur_addr_nxt;
    logic [BEAT_W-1:0]     remaining, remaining_nxt;
    logic [DATA_WIDTH-1:0] hold, hold_nxt;
    logic [ADDR_WIDTH-1:0] offset;
    logic                  in_range;

    // Range test by shifting the offset so the SRAM size never has to be materialised.
    assign offset    = cur_addr - BASE_ADDR;
    assign in_range  = (cur_addr >= BASE_ADDR) && ((offset >> RANGE_SH) == '0);
    assign mem_addr  = MEM_AW'(offset >> BYTE_SH);
    assign mem_wdata = write_data;
    assign mem_wstrb = write_strb;
    assign read_data = hold;

    // State, beat bookkeeping and registered handshake/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cur_addr    <= '0;
            remaining   <= '0;
            hold        <= '0;
            req_ready   <= 1'b0;
            busy        <= 1'b0;
            write_ready <= 1'b0;
            read_valid  <= 1'b0;
        end else begin
            state       <= state_nxt;
            cur_addr    <= cur_addr_nxt;
            remaining   <= remaining_nxt;
            hold        <= hold_nxt;
            req_ready   <= (state_nxt == S_IDLE);
            busy        <= (state_nxt != S_IDLE);
            write_ready <= (state_nxt == S_WR);
            read_valid  <= (state_nxt == S_RD_DATA);
        end
    end

    // Next-state logic; SRAM strobes and err are same-cycle by design.
    always_comb begin
        state_nxt     = state;
        cur_addr_nxt  = cur_addr;
        remaining_nxt = remaining;
        hold_nxt      = hold;
        mem_en        = 1'b0;
        mem_we        = 1'b0;
        err           = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    cur_addr_nxt  = req_addr;
                    remaining_nxt = (req_burst && (req_beats != '0)) ? req_beats : BEAT_W'(1);
                    state_nxt     = req_rw ? S_WR : S_RD_ADDR;
                end
            end
            S_WR: begin
                if (write_valid) begin
                    mem_en        = in_range;
                    mem_we        = 1'b1;
                    err           = !in_range;
                    cur_addr_nxt  = cur_addr + ADDR_WIDTH'(STRB_W);
                    remaining_nxt = remaining - BEAT_W'(1);
                    if (remaining == BEAT_W'(1)) begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_RD_ADDR: begin
                mem_en    = in_range;
                state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                hold_nxt  = in_range ? mem_rdata : '0;
                err       = !in_range;
                state_nxt = S_RD_DATA;
            end
            S_RD_DATA: begin
                if (read_ready) begin
                    cur_addr_nxt  = cur_addr + ADDR_WIDTH'(STRB_W);
                    remaining_nxt = remaining - BEAT_W'(1);
                    state_nxt     = (remaining == BEAT_W'(1)) ? S_IDLE : S_RD_ADDR;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mam_mem_responder.sv
// Randomised self-checking bench for mam_mem_responder against a word-array reference memory.
module tb_mam_mem_responder;

    localparam int unsigned WORDS = 1024;
    localparam int unsigned SW    = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_rw, req_burst;
    logic [63:0] req_addr;
    logic [13:0] req_beats;
    logic        write_valid, write_ready;
    logic [63:0] write_data;
    logic [7:0]  write_strb;
    logic        read_valid, read_ready;
    logic [63:0] read_data;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [63:0] mem_wdata, mem_rdata;
    logic [7:0]  mem_wstrb;
    logic        busy, err;

    always #5 clk = ~clk;

    mam_mem_responder dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_burst(req_burst), .req_beats(req_beats),
        .write_valid(write_valid), .write_ready(write_ready),
        .write_data(write_data), .write_strb(write_strb),
        .read_valid(read_valid), .read_ready(read_ready), .read_data(read_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .busy(busy), .err(err)
    );

    logic [63:0] sram    [WORDS];
    logic [63:0] ref_mem [WORDS];
    logic [63:0] mw;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int err_cnt = 0;
    int n_checks = 0;
    int n_fail = 0;

    // SRAM model plus access/err counters.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mw = sram[mem_addr];
                for (int b = 0; b < 8; b++) if (mem_wstrb[b]) mw[8*b +: 8] = mem_wdata[8*b +: 8];
                sram[mem_addr] <= mw;
                wr_cnt = wr_cnt + 1;
            end else begin
                mem_rdata <= sram[mem_addr];
                rd_cnt = rd_cnt + 1;
            end
        end
        if (err) err_cnt = err_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic in_rng(input logic [63:0] a);
        return a < 64'(WORDS * SW);
    endfunction

    function automatic int word_of(input logic [63:0] a);
        return int'(a / 64'(SW));
    endfunction

    function automatic int exp_beats(input logic burst, input logic [13:0] beats);
        if (!burst) return 1;
        return (beats == 14'd0) ? 1 : int'(beats);
    endfunction

    task automatic do_req(input logic rw, input logic [63:0] addr, input logic burst,
                          input logic [13:0] beats);
        int t = 0;
        @(negedge clk);
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("req_ready_wait", 64'(t < 50), 64'd1);
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = addr;
        req_burst = burst;
        req_beats = beats;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // gap_mode: 0 = back-to-back, 1 = one idle cycle before every beat, 2 = random gaps.
    task automatic write_txn(input logic [63:0] addr, input logic burst, input logic [13:0] beats,
                             input int gap_mode, input logic [63:0] d0, input logic rnd);
        int n = exp_beats(burst, beats);
        int w0 = wr_cnt;
        int nw = 0;
        logic [63:0] a = addr;
        do_req(1'b1, addr, burst, beats);
        for (int i = 0; i < n; i++) begin
            int g = (gap_mode == 1) ? 1 : ((gap_mode == 2) ? int'($urandom_range(0, 2)) : 0);
            logic [63:0] d = rnd ? {$urandom, $urandom} : d0 + 64'(i);
            logic [7:0]  s = rnd ? 8'($urandom_range(0, 255)) : 8'hFF;
            for (int j = 0; j < g; j++) begin
                @(negedge clk);
                req_valid = 1'b1;
                req_rw    = 1'b0;
                #1;
                check("wr_gap_mem_en", 64'(mem_en), 64'd0);
                check("busy_req_ready", 64'(req_ready), 64'd0);
            end
            @(negedge clk);
            req_valid   = 1'b0;
            write_valid = 1'b1;
            write_data  = d;
            write_strb  = s;
            #1;
            check("wr_ready", 64'(write_ready), 64'd1);
            check("wr_mem_en", 64'(mem_en), 64'(in_rng(a)));
            check("wr_mem_we", 64'(mem_we), 64'd1);
            check("wr_err", 64'(err), 64'(!in_rng(a)));
            if (in_rng(a)) begin
                check("wr_mem_addr", 64'(mem_addr), 64'(word_of(a)));
                check("wr_mem_wdata", mem_wdata, d);
                check("wr_mem_wstrb", 64'(mem_wstrb), 64'(s));
                for (int b = 0; b < 8; b++) if (s[b]) ref_mem[word_of(a)][8*b +: 8] = d[8*b +: 8];
                nw++;
            end
            @(posedge clk);
            #1 write_valid = 1'b0;
            a = a + 64'(SW);
        end
        @(negedge clk);
        #1;
        check("wr_done_busy", 64'(busy), 64'd0);
        check("wr_done_req_ready", 64'(req_ready), 64'd1);
        check("wr_sram_count", 64'(wr_cnt - w0), 64'(nw));
    endtask

    task automatic read_txn(input logic [63:0] addr, input logic burst, input logic [13:0] beats,
                            input int stall_beat, input int stall_len, input logic rnd);
        int n = exp_beats(burst, beats);
        int r0 = rd_cnt;
        int e0 = err_cnt;
        int nr = 0;
        int ne = 0;
        logic [63:0] a = addr;
        read_ready = 1'b0;
        do_req(1'b0, addr, burst, beats);
        for (int i = 0; i < n; i++) begin
            int k = 0;
            logic rv = 1'b0;
            int st;
            logic [63:0] exp_d;
            while (!rv && k < 20) begin
                @(negedge clk);
                k++;
                #1;
                if (k == 1) begin
                    check("rd_mem_en", 64'(mem_en), 64'(in_rng(a)));
                    check("rd_mem_we", 64'(mem_we), 64'd0);
                    if (in_rng(a)) check("rd_mem_addr", 64'(mem_addr), 64'(word_of(a)));
                end
                if (k == 2) check("rd_err", 64'(err), 64'(!in_rng(a)));
                rv = read_valid;
            end
            check("rd_latency", 64'(k), 64'd3);
            exp_d = in_rng(a) ? ref_mem[word_of(a)] : 64'd0;
            check("rd_data", read_data, exp_d);
            st = (i == stall_beat) ? stall_len : (rnd ? int'($urandom_range(0, 2)) : 0);
            for (int s = 0; s < st; s++) begin
                @(negedge clk);
                #1;
                check("rd_stall_valid", 64'(read_valid), 64'd1);
                check("rd_stall_data", read_data, exp_d);
            end
            read_ready = 1'b1;
            @(posedge clk);
            #1 read_ready = 1'b0;
            if (in_rng(a)) nr++;
            else ne++;
            a = a + 64'(SW);
        end
        @(negedge clk);
        #1;
        check("rd_done_busy", 64'(busy), 64'd0);
        check("rd_done_req_ready", 64'(req_ready), 64'd1);
        check("rd_done_valid", 64'(read_valid), 64'd0);
        check("rd_sram_count", 64'(rd_cnt - r0), 64'(nr));
        check("rd_err_count", 64'(err_cnt - e0), 64'(ne));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w0;
        for (int i = 0; i < int'(WORDS); i++) begin
            sram[i]    = 64'd0;
            ref_mem[i] = 64'd0;
        end
        mem_rdata   = 64'd0;
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_rw      = 1'b0;
        req_addr    = 64'd0;
        req_burst   = 1'b0;
        req_beats   = 14'd0;
        write_valid = 1'b0;
        write_data  = 64'd0;
        write_strb  = 8'd0;
        read_ready  = 1'b0;

        // Reset state
        #2;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_write_ready", 64'(write_ready), 64'd0);
        check("rst_read_valid", 64'(read_valid), 64'd0);
        check("rst_mem_en", 64'(mem_en), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_read_data", read_data, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("post_rst_req_ready", 64'(req_ready), 64'd1);

        // Single write then read
        write_txn(64'h10, 1'b0, 14'd0, 0, 64'hA5A5_0000_1111_2222, 1'b0);
        read_txn(64'h10, 1'b0, 14'd0, -1, 0, 1'b0);

        // Gapped 4-beat burst write, then stalled 3-beat burst read
        write_txn(64'h0, 1'b1, 14'd4, 1, 64'h1000_0000_0000_0000, 1'b0);
        read_txn(64'h0, 1'b1, 14'd3, 1, 5, 1'b0);

        // Range edges
        write_txn(64'h1FF8, 1'b0, 14'd0, 0, 64'hDEAD_BEEF_0123_4567, 1'b0);
        read_txn(64'h1FF8, 1'b0, 14'd0, -1, 0, 1'b0);
        read_txn(64'h2000, 1'b0, 14'd0, -1, 0, 1'b0);
        write_txn(64'h2008, 1'b0, 14'd0, 0, 64'h1234, 1'b0);

        // Edge lengths
        write_txn(64'h40, 1'b1, 14'd0, 0, 64'h4444, 1'b0);
        read_txn(64'h40, 1'b0, 14'd7, -1, 0, 1'b0);

        // Reset during beat 2 of a 4-beat write
        do_req(1'b1, 64'h100, 1'b1, 14'd4);
        @(negedge clk);
        write_valid = 1'b1;
        write_data  = 64'h5151_5151_5151_5151;
        write_strb  = 8'hFF;
        #1;
        check("mid_rst_beat1_en", 64'(mem_en), 64'd1);
        ref_mem[word_of(64'h100)] = 64'h5151_5151_5151_5151;
        @(posedge clk);
        #1 write_valid = 1'b0;
        w0 = wr_cnt;
        @(negedge clk);
        write_valid = 1'b1;
        write_data  = 64'h6262_6262_6262_6262;
        #1 rst = 1'b1;
        #1;
        check("mid_rst_mem_en", 64'(mem_en), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_write_ready", 64'(write_ready), 64'd0);
        check("mid_rst_req_ready", 64'(req_ready), 64'd0);
        check("mid_rst_read_valid", 64'(read_valid), 64'd0);
        check("mid_rst_err", 64'(err), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("mid_rst_req_ready_back", 64'(req_ready), 64'd1);
        repeat (3) @(negedge clk);
        write_valid = 1'b0;
        check("mid_rst_no_residual", 64'(wr_cnt - w0), 64'd0);
        read_txn(64'h100, 1'b1, 14'd2, -1, 0, 1'b0);

        // Randomised mixed traffic
        for (int t = 0; t < 40; t++) begin
            logic        rw    = 1'($urandom_range(0, 1));
            logic [63:0] addr  = 64'($urandom_range(0, 8191 + 48));
            logic        burst = 1'($urandom_range(0, 1));
            logic [13:0] beats = 14'($urandom_range(0, burst ? 5 : 15));
            if (rw) write_txn(addr, burst, beats, 2, 64'd0, 1'b1);
            else    read_txn(addr, burst, beats, -1, 0, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
